// File: rtl/spi_peripheral.sv
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first.
// SCLK, CS and MOSI are oversampled in the clk_system domain through
// synchronizers. Received words appear as a one-cycle rx_valid pulse.
// MISO is served from a one-entry transmit buffer written by the system side.
module spi_peripheral #(
  parameter int reg_width     = 8,
  parameter int counter_width = $clog2(reg_width),
  parameter int sync_stages   = 2
) (
  input  logic                 clk_system,
  input  logic                 reset_system,
  input  logic [reg_width-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic [reg_width-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 busy,
  input  logic                 clk_spi,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [counter_width:0] CNT_ZERO = '0;
  localparam logic [counter_width:0] CNT_ONE  = (counter_width+1)'(1);
  localparam logic [counter_width:0] CNT_FULL = (counter_width+1)'(reg_width);

  logic [sync_stages-1:0] sclk_sync_q, sclk_sync_d;
  logic [sync_stages-1:0] cs_sync_q,   cs_sync_d;
  logic [sync_stages-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [1:0]             state_q,     state_d;
  logic [counter_width:0] cnt_q,       cnt_d;
  logic [reg_width-1:0]   shift_tx_q,  shift_tx_d;
  logic [reg_width-1:0]   shift_rx_q,  shift_rx_d;
  logic [reg_width-1:0]   buf_q,       buf_d;
  logic                   tx_ready_q,  tx_ready_d;
  logic [reg_width-1:0]   rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   busy_q,      busy_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise_s, sclk_fall_s;
  logic consume_s;
  logic [counter_width:0] cnt_inc_s;

  assign sclk_s      = sclk_sync_q[sync_stages-1];
  assign cs_s        = cs_sync_q[sync_stages-1];
  assign mosi_s      = mosi_sync_q[sync_stages-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cnt_inc_s   = cnt_q + CNT_ONE;

  // Synchronizer shift chains and SCLK edge history.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[sync_stages-2:0], clk_spi};
    cs_sync_d   = {cs_sync_q[sync_stages-2:0], cs};
    mosi_sync_d = {mosi_sync_q[sync_stages-2:0], mosi};
    sclk_prev_d = sclk_s;
  end

  // Frame state machine, shift registers and transmit buffer handshake.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    buf_d         = buf_q;
    tx_ready_d    = tx_ready_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    consume_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stay deaf until CS is seen high, so a frame cut by reset is skipped.
        if (cs_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // ARMED is only entered with cs_s high, so cs_s low here is the fall.
        if (!cs_s) begin
          state_d   = ST_ACTIVE;
          cnt_d     = CNT_ZERO;
          consume_s = 1'b1;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (cs_s) begin
          // Abort or normal end: a partial word is dropped silently.
          state_d = ST_ARMED;
          cnt_d   = CNT_ZERO;
        end else if (sclk_rise_s) begin
          shift_rx_d = {shift_rx_q[reg_width-2:0], mosi_s};
          if (cnt_inc_s == CNT_FULL) begin
            rx_data_d  = shift_rx_d;
            rx_valid_d = 1'b1;
            cnt_d      = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else if (sclk_fall_s) begin
          if (cnt_q != CNT_ZERO) begin
            shift_tx_d = {shift_tx_q[reg_width-2:0], 1'b0};
          end else begin
            // Word boundary inside a frame: start the next outgoing word.
            consume_s = 1'b1;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Move the buffered word into the shifter, or send zeros if none waits.
    if (consume_s) begin
      if (!tx_ready_q) begin
        shift_tx_d = buf_q;
        tx_ready_d = 1'b1;
      end else begin
        shift_tx_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end else begin
      tx_underrun_d = 1'b0;
    end

    // Writes only land in an empty buffer; a consume from empty in the same
    // cycle has already sent zeros, so the new word waits for the next one.
    if (tx_load && tx_ready_q) begin
      buf_d      = tx_data;
      tx_ready_d = 1'b0;
    end else begin
      buf_d = buf_d;
    end

    busy_d = (state_d != ST_IDLE) && !cs_s;
  end

  // State registers with synchronous active-low reset. Synchronizers reset
  // to 0 so a CS held low across reset release never looks like a CS fall.
  always_ff @(posedge clk_system) begin
    if (!reset_system) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      buf_q         <= '0;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      buf_q         <= buf_d;
      tx_ready_q    <= tx_ready_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      busy_q        <= busy_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;

  // MISO is released as soon as the raw CS goes high, independent of sync.
  assign miso = cs ? 1'bz : shift_tx_q[reg_width-1];

endmodule
